adc_lane_serializer: RTL

//   Transmit-side emulator of the 2-lane-per-channel LVDS ADC link, driving the deserializer path from fabric.

---
 rtl/adc_lane_serializer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/adc_lane_serializer.sv
// rtl/adc_lane_serializer.sv - LVDS ADC 2-lane/channel transmit emulator; optional ADC_TX_TESTPAT_EN adds a ramp test pattern
module adc_lane_serializer #(
  parameter int NCH     = 4,
  parameter int FRM_LEN = 8
) (
  input  logic              clk,
  input  logic              asyncrst_n,
  input  logic              en,
  input  logic [16*NCH-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              slip_req,
`ifdef ADC_TX_TESTPAT_EN
  input  logic              test_mode,
`endif
  output logic [NCH-1:0]    lane_d1,
  output logic [NCH-1:0]    lane_d0,
  output logic              fco,
  output logic              frame_start,
  output logic [15:0]       underrun_cnt
);

  localparam int CW = $clog2(FRM_LEN);
  localparam logic [CW-1:0] LAST = CW'(FRM_LEN - 1);
  localparam logic [CW-1:0] HALF = CW'(FRM_LEN / 2);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STRETCH} state_t;

  logic tm_in;
`ifdef ADC_TX_TESTPAT_EN
  assign tm_in = test_mode;
`else
  assign tm_in = 1'b0;
`endif

  state_t            state_q, state_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              slip_pend_q, slip_pend_d;
  logic              win_q, win_d;          // current cycle is an accept window
  logic              tm_q, tm_d;            // window loads the ramp instead of s_data
  logic [16*NCH-1:0] hold_q, hold_d;
  logic [15:0]       underrun_q, underrun_d;
  logic              s_ready_q, s_ready_d;
  logic [NCH-1:0]    lane_d1_q, lane_d1_d;
  logic [NCH-1:0]    lane_d0_q, lane_d0_d;
  logic              fco_q, fco_d;
  logic              frame_start_q, frame_start_d;
  logic              show;
  logic [15:0]       sh;
`ifdef ADC_TX_TESTPAT_EN
  logic [15:0]       ramp_q, ramp_d;
`endif

  // Next phase of the frame, sample capture at window close, and the registered lane/frame outputs
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    slip_pend_d   = slip_pend_q | slip_req;
    win_d         = 1'b0;
    tm_d          = tm_q;
    hold_d        = hold_q;
    underrun_d    = underrun_q;
    lane_d1_d     = '0;
    lane_d0_d     = '0;
    fco_d         = 1'b0;
    frame_start_d = 1'b0;
    show          = 1'b0;
    sh            = '0;
`ifdef ADC_TX_TESTPAT_EN
    ramp_d        = ramp_q;
`endif

    // A window closes on this edge whether or not en stays high: the handshake already happened
    if (win_q) begin
      if (tm_q) begin
`ifdef ADC_TX_TESTPAT_EN
        for (int k = 0; k < NCH; k++) begin
          hold_d[16*k +: 16] = ramp_q + 16'(k);
        end
        ramp_d = ramp_q + 16'd1;
`endif
      end else if (s_valid) begin
        hold_d = s_data;
      end else if (underrun_q != 16'hFFFF) begin
        underrun_d = underrun_q + 16'd1;
      end
    end

    if (!en) begin
      state_d   = ST_IDLE;
      bit_cnt_d = LAST;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // first enabled cycle is a bare accept window with quiet lanes
          state_d   = ST_RUN;
          bit_cnt_d = LAST;
          win_d     = 1'b1;
          tm_d      = tm_in;
        end
        ST_RUN: begin
          if (bit_cnt_q == LAST) begin
            if (win_q) begin
              bit_cnt_d = '0;
              show      = 1'b1;
            end else begin
              // first half of a slipped bit 7: repeat it and open the window next cycle
              state_d = ST_STRETCH;
              win_d   = 1'b1;
              tm_d    = tm_in;
              show    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
            show      = 1'b1;
            if (bit_cnt_d == LAST) begin
              if (slip_pend_q | slip_req) begin
                slip_pend_d = 1'b0;
              end else begin
                win_d = 1'b1;
                tm_d  = tm_in;
              end
            end
          end
        end
        ST_STRETCH: begin
          state_d   = ST_RUN;
          bit_cnt_d = '0;
          show      = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    s_ready_d = win_d & ~tm_d;

    if (show) begin
      for (int k = 0; k < NCH; k++) begin
        sh           = hold_d[16*k +: 16] << {bit_cnt_d, 1'b0};
        lane_d1_d[k] = sh[15];
        lane_d0_d[k] = sh[14];
      end
      fco_d         = (bit_cnt_d < HALF);
      frame_start_d = (bit_cnt_d == '0);
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge asyncrst_n) begin
    if (!asyncrst_n) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= LAST;
      slip_pend_q   <= 1'b0;
      win_q         <= 1'b0;
      tm_q          <= 1'b0;
      hold_q        <= '0;
      underrun_q    <= '0;
      s_ready_q     <= 1'b0;
      lane_d1_q     <= '0;
      lane_d0_q     <= '0;
      fco_q         <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      slip_pend_q   <= slip_pend_d;
      win_q         <= win_d;
      tm_q          <= tm_d;
      hold_q        <= hold_d;
      underrun_q    <= underrun_d;
      s_ready_q     <= s_ready_d;
      lane_d1_q     <= lane_d1_d;
      lane_d0_q     <= lane_d0_d;
      fco_q         <= fco_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef ADC_TX_TESTPAT_EN
  // Test-pattern ramp counter
  always_ff @(posedge clk or negedge asyncrst_n) begin
    if (!asyncrst_n) begin
      ramp_q <= '0;
    end else begin
      ramp_q <= ramp_d;
    end
  end
`endif

  assign s_ready      = s_ready_q;
  assign lane_d1      = lane_d1_q;
  assign lane_d0      = lane_d0_q;
  assign fco          = fco_q;
  assign frame_start  = frame_start_q;
  assign underrun_cnt = underrun_q;

endmodule
